mem_ctrl_slave: RTL and testbench

Main-bus slave memory controller that sits directly downstream of the processor-side bus master. It answers 4-beat burst read and write transactions on the shared tristate AddrData bus. Each instance owns one 4K-word page of memory, selected by the upper 4 address bits. The memory is a synchronous-write, asynchronous-read word array.

---
 rtl/mem_ctrl_slave_if.sv | 33 +++
 rtl/mem_ctrl_slave.sv | 93 +++++++++
 tb/tb_mem_ctrl_slave.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_slave_if.sv
// Processor-side main bus seen by a mem_ctrl_slave: handshake, shared tristate AddrData, busy.
// proto_err is present only when MEMCTL_PROTO_CHECK_EN is defined.
interface mem_ctrl_slave_if #(
  parameter int unsigned BUSWIDTH = 16
) ();
  logic                AddrValid;
  logic                rw;
  wire  [BUSWIDTH-1:0] AddrData;
  logic                busy;
`ifdef MEMCTL_PROTO_CHECK_EN
  logic                proto_err;
`endif

  modport master (
    output AddrValid,
    output rw,
    inout  AddrData,
    input  busy
`ifdef MEMCTL_PROTO_CHECK_EN
    , input proto_err
`endif
  );

  modport slave (
    input  AddrValid,
    input  rw,
    inout  AddrData,
    output busy
`ifdef MEMCTL_PROTO_CHECK_EN
    , output proto_err
`endif
  );
endinterface

// File: rtl/mem_ctrl_slave.sv
// Main-bus slave owning one page of memory; answers 4-beat burst reads/writes on AddrData.
// Optional sticky protocol checker enabled by defining MEMCTL_PROTO_CHECK_EN.
module mem_ctrl_slave #(
  parameter int unsigned          BUSWIDTH        = 16,
  parameter int unsigned          DATAPAYLOADSIZE = 4,
  parameter int unsigned          PAGEWIDTH       = 4,
  parameter logic [PAGEWIDTH-1:0] PAGE            = '0,
  parameter int unsigned          ADDRWIDTH       = 12
) (
  input  logic            clk,
  input  logic            resetN,
  mem_ctrl_slave_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RDATA = 2'd1,
    WDATA = 2'd2
  } state_t;

  localparam logic [1:0] LAST_BEAT = 2'(DATAPAYLOADSIZE - 1);

  state_t               state;
  state_t               state_nx;
  logic [1:0]           beat;
  logic [ADDRWIDTH-1:0] offset;
  logic [ADDRWIDTH-1:0] mem_addr;
  logic [BUSWIDTH-1:0]  rd_data;
  logic                 page_hit;
  logic                 drive_en;

  logic [BUSWIDTH-1:0]  mem [2**ADDRWIDTH];

  assign page_hit = bus.AddrValid &&
                    (bus.AddrData[BUSWIDTH-1 -: PAGEWIDTH] == PAGE);

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      beat     <= '0;
      offset   <= '0;
      bus.busy <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.busy <= (state_nx != IDLE);
      if (state == IDLE) begin
        beat <= '0;
        if (page_hit) offset <= bus.AddrData[ADDRWIDTH-1:0];
      end else begin
        beat <= beat + 2'd1;
      end
    end
  end

  // Requests arriving mid-burst are dropped, not queued.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:         if (page_hit) state_nx = bus.rw ? RDATA : WDATA;
      RDATA, WDATA: if (beat == LAST_BEAT) state_nx = IDLE;
      default:      state_nx = IDLE;
    endcase
  end

  // Offset wraps inside the page; drive enable decodes registered state only.
  always_comb begin
    drive_en = (state == RDATA);
    mem_addr = offset + ADDRWIDTH'(beat);
  end

  assign rd_data      = mem[mem_addr];
  assign bus.AddrData = drive_en ? rd_data : 'z;

  always_ff @(posedge clk) begin
    if (state == WDATA) mem[mem_addr] <= bus.AddrData;
  end

`ifdef MEMCTL_PROTO_CHECK_EN
  logic rw_q;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rw_q          <= 1'b0;
      bus.proto_err <= 1'b0;
    end else begin
      rw_q <= bus.rw;
      if ((state != IDLE) && (page_hit || (bus.rw != rw_q)))
        bus.proto_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_ctrl_slave.sv
// Bench for mem_ctrl_slave: table-driven bursts, hand-written corner sequences,
// then random bursts checked against a transaction-level memory model.
module tb_mem_ctrl_slave;

  typedef struct packed {
    logic [15:0]      addr;
    logic             rd;
    logic             hit;
    logic [1:0]       gap;
    logic [3:0][15:0] d;
  } vec_t;

  logic        clk;
  logic        resetN;
  logic        m_en;
  logic [15:0] m_data;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [15:0] ref_mem [4096];
  logic [11:0] bases [$];
  vec_t        tbl [11];

  mem_ctrl_slave_if #(.BUSWIDTH(16)) bus_if ();

  assign bus_if.AddrData = m_en ? m_data : 'z;

  mem_ctrl_slave #(
    .BUSWIDTH(16),
    .DATAPAYLOADSIZE(4),
    .PAGEWIDTH(4),
    .PAGE(4'h0),
    .ADDRWIDTH(12)
  ) dut (
    .clk(clk),
    .resetN(resetN),
    .bus(bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // A released bus reads as z in 4-state simulators and 0 in 2-state ones.
  task automatic check_rel(input string name);
    n_tests++;
    if (!((bus_if.AddrData === 16'hzzzz) || (bus_if.AddrData === 16'h0000))) begin
      n_fail++;
      $display("FAIL %s: got %h expected released bus", name, bus_if.AddrData);
    end
  endtask

  task automatic check_proto(input string name, input logic exp);
`ifdef MEMCTL_PROTO_CHECK_EN
    check(name, bus_if.proto_err, exp);
`else
    if (name.len() == 0 && exp) $display("%s", name);
`endif
  endtask

  // Runs one burst from T0 to T5; writes that hit page 0 update the model.
  task automatic burst(input logic [15:0] addr, input logic rd,
                       input logic [3:0][15:0] wd, output logic [3:0][15:0] got);
    logic hit;
    hit = (addr[15:12] == 4'h0);
    got = '0;
    bus_if.AddrValid = 1'b1;
    bus_if.rw        = rd;
    m_en             = 1'b1;
    m_data           = addr;
    #1;
    check("busy_t0", bus_if.busy, 1'b0);
    step();
    bus_if.AddrValid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_en   = !rd;
      m_data = wd[i];
      #1;
      check($sformatf("busy_beat%0d", i), bus_if.busy, hit);
      if (rd) begin
        if (hit) got[i] = bus_if.AddrData;
        else     check_rel($sformatf("miss_bus_beat%0d", i));
      end
      step();
    end
    m_en = 1'b0;
    #1;
    check("busy_t5", bus_if.busy, 1'b0);
    check_rel("bus_t5");
    if (!rd && hit)
      for (int i = 0; i < 4; i++) ref_mem[12'(addr[11:0] + 12'(i))] = wd[i];
  endtask

  initial begin
    logic [3:0][15:0] got;
    logic [3:0][15:0] wd;
    logic [15:0]      addr;
    logic [11:0]      off;
    logic             rd;

    tbl[0]  = '{addr:16'h0010, rd:1'b0, hit:1'b1, gap:2'd1, d:{16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    tbl[1]  = '{addr:16'h0010, rd:1'b1, hit:1'b1, gap:2'd1, d:{16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    tbl[2]  = '{addr:16'h0002, rd:1'b0, hit:1'b1, gap:2'd1, d:{16'hB005, 16'hB004, 16'hB003, 16'hB002}};
    tbl[3]  = '{addr:16'h0FFE, rd:1'b0, hit:1'b1, gap:2'd2, d:{16'hA3A3, 16'hA2A2, 16'hA1A1, 16'hA0A0}};
    tbl[4]  = '{addr:16'h0FFE, rd:1'b1, hit:1'b1, gap:2'd1, d:{16'hA3A3, 16'hA2A2, 16'hA1A1, 16'hA0A0}};
    tbl[5]  = '{addr:16'h0000, rd:1'b1, hit:1'b1, gap:2'd1, d:{16'hB003, 16'hB002, 16'hA3A3, 16'hA2A2}};
    tbl[6]  = '{addr:16'h2010, rd:1'b1, hit:1'b0, gap:2'd1, d:'0};
    tbl[7]  = '{addr:16'h2010, rd:1'b0, hit:1'b0, gap:2'd1, d:{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D}};
    tbl[8]  = '{addr:16'h0010, rd:1'b1, hit:1'b1, gap:2'd1, d:{16'h4444, 16'h3333, 16'h2222, 16'h1111}};
    tbl[9]  = '{addr:16'h0100, rd:1'b0, hit:1'b1, gap:2'd1, d:{16'h0C04, 16'h0C03, 16'h0C02, 16'h0C01}};
    tbl[10] = '{addr:16'h0100, rd:1'b1, hit:1'b1, gap:2'd0, d:{16'h0C04, 16'h0C03, 16'h0C02, 16'h0C01}};

    resetN           = 1'b0;
    m_en             = 1'b0;
    m_data           = '0;
    bus_if.AddrValid = 1'b0;
    bus_if.rw        = 1'b0;
    #3;
    check("reset_busy", bus_if.busy, 1'b0);
    check_rel("reset_bus");
    check_proto("reset_proto", 1'b0);
    #20 resetN = 1'b1;
    step();

    for (int v = 0; v < 11; v++) begin
      repeat (int'(tbl[v].gap)) step();
      burst(tbl[v].addr, tbl[v].rd, tbl[v].d, got);
      if (tbl[v].rd && tbl[v].hit)
        for (int i = 0; i < 4; i++)
          check($sformatf("tbl%0d_rd%0d", v, i), got[i], tbl[v].d[i]);
    end
    check_proto("proto_clean", 1'b0);

    // Mid-burst AddrValid with rw flipped: read completes, nothing written.
    step();
    bus_if.AddrValid = 1'b1; bus_if.rw = 1'b1; m_en = 1'b1; m_data = 16'h0010;
    step();
    bus_if.AddrValid = 1'b0; m_en = 1'b0;
    #1 check("mid_t1", bus_if.AddrData, 16'h1111);
    step();
    bus_if.AddrValid = 1'b1; bus_if.rw = 1'b0;
    #1 check("mid_t2", bus_if.AddrData, 16'h2222);
    step();
    bus_if.AddrValid = 1'b0; bus_if.rw = 1'b1;
    #1 check("mid_t3", bus_if.AddrData, 16'h3333);
    check_proto("mid_proto_t3", 1'b1);
    step();
    #1 check("mid_t4", bus_if.AddrData, 16'h4444);
    check("mid_busy_t4", bus_if.busy, 1'b1);
    step();
    #1 check("mid_busy_t5", bus_if.busy, 1'b0);
    check_rel("mid_bus_t5");
    check_proto("mid_proto_t5", 1'b1);
    burst(16'h0010, 1'b1, '0, got);
    for (int i = 0; i < 4; i++) check($sformatf("mid_after_rd%0d", i), got[i], ref_mem[12'h010 + 12'(i)]);

    // Asynchronous reset in the middle of a read.
    step();
    bus_if.AddrValid = 1'b1; bus_if.rw = 1'b1; m_en = 1'b1; m_data = 16'h0010;
    step();
    bus_if.AddrValid = 1'b0; m_en = 1'b0;
    #1 check("rst_t1", bus_if.AddrData, 16'h1111);
    step();
    #1 check("rst_t2", bus_if.AddrData, 16'h2222);
    #2 resetN = 1'b0;
    #1 check("rst_busy", bus_if.busy, 1'b0);
    check_rel("rst_bus");
    check_proto("rst_proto", 1'b0);
    step();
    step();
    resetN = 1'b1;
    step();
    burst(16'h0010, 1'b1, '0, got);
    for (int i = 0; i < 4; i++)
      check($sformatf("rst_after_rd%0d", i), got[i], {4{4'(i + 1)}});

    for (int t = 0; t < 40; t++) begin
      repeat ($urandom_range(0, 2)) step();
      rd = 1'($urandom_range(0, 1));
      wd = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) begin
        addr = {4'($urandom_range(1, 15)), 12'($urandom())};
      end else if (rd && bases.size() > 0) begin
        addr = {4'h0, bases[$urandom_range(0, bases.size() - 1)]};
      end else begin
        rd   = 1'b0;
        off  = ($urandom_range(0, 3) == 0) ? 12'hFFC + 12'($urandom_range(0, 3)) : 12'($urandom());
        addr = {4'h0, off};
        bases.push_back(off);
      end
      burst(addr, rd, wd, got);
      if (rd && addr[15:12] == 4'h0)
        for (int i = 0; i < 4; i++)
          check($sformatf("rnd%0d_rd%0d", t, i), got[i], ref_mem[12'(addr[11:0] + 12'(i))]);
    end
    check_proto("proto_end", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
